// File: rtl/radix2_divider_pkg.sv
// Shared types and helpers for the radix-2 non-restoring divider.
// Latency and backpressure: none (declarations only).
package radix2_divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } state_t;

  // Widest operand abs_u can handle; the top refuses anything wider.
  localparam int ABS_MAX_W = 64;

  function automatic int cntr_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

  // Magnitude as an unsigned value, so the most negative input maps exactly to 2^(n-1).
  function automatic logic [ABS_MAX_W-1:0] abs_u(input logic signed [ABS_MAX_W-1:0] x);
    return x[ABS_MAX_W-1] ? $unsigned(-x) : $unsigned(x);
  endfunction

endpackage

// File: rtl/nonrestoring_div_step.sv
// One non-restoring iteration: shift {P,A} left, add or subtract D by the sign of old P.
// Latency: combinational. Backpressure: none.
module nonrestoring_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   p_next,
  output logic [WIDTH-1:0] a_next
);

  logic [WIDTH:0] p_sh;
  logic [WIDTH:0] d_ext;

  always_comb begin
    p_sh   = {p[WIDTH-1:0], a[WIDTH-1]};
    d_ext  = {1'b0, d};
    p_next = p[WIDTH] ? (p_sh + d_ext) : (p_sh - d_ext);
    a_next = {a[WIDTH-2:0], ~p_next[WIDTH]};
  end

endmodule

// File: rtl/radix2_nonrestoring_divider.sv
// Signed WIDTH-bit divider (truncating; remainder follows dividend sign); optional RADIX2_DIVIDER_DIV0_DETECT_EN.
// Latency: done WIDTH+2 cycles after start (1 cycle on detected zero divisor). Backpressure: start ignored while busy.
module radix2_nonrestoring_divider
  import radix2_divider_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter bit CHECK_PARAM = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] dividend,
  input  logic signed [WIDTH-1:0] divisor,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] quotient,
  output logic signed [WIDTH-1:0] remainder,
  output logic                    div_by_zero
);

  if (CHECK_PARAM && (WIDTH < 2 || WIDTH > ABS_MAX_W)) begin : g_width_check
    $fatal(1, "radix2_nonrestoring_divider: unsupported WIDTH %0d", WIDTH);
  end

  localparam int CW = cntr_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH:0]   p_q;
  logic [WIDTH:0]   p_step;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] a_step;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cntr;
  logic             neg_dvd;
  logic             neg_dvs;
  logic             accept;
  logic             zero_div;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] quot_nxt;
  logic [WIDTH-1:0] rem_nxt;

  assign accept = start && ((state == IDLE) || (state == DONE));

`ifdef RADIX2_DIVIDER_DIV0_DETECT_EN
  assign zero_div = (divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  nonrestoring_div_step #(.WIDTH(WIDTH)) u_step (
    .p      (p_q),
    .a      (a_q),
    .d      (d_q),
    .p_next (p_step),
    .a_next (a_step)
  );

  // Final restore: low bits of P+D are exact because the remainder is below D.
  always_comb begin
    r_mag    = p_q[WIDTH] ? (p_q[WIDTH-1:0] + d_q) : p_q[WIDTH-1:0];
    quot_nxt = (neg_dvd ^ neg_dvs) ? -a_q : a_q;
    rem_nxt  = neg_dvd ? -r_mag : r_mag;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) state_nxt = zero_div ? DONE : ITER;
        else       state_nxt = IDLE;
      end
      ITER: begin
        busy = 1'b1;
        if (cntr == LAST) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q         <= '0;
      a_q         <= '0;
      d_q         <= '0;
      cntr        <= '0;
      neg_dvd     <= 1'b0;
      neg_dvs     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            neg_dvd     <= dividend[WIDTH-1];
            neg_dvs     <= divisor[WIDTH-1];
            a_q         <= WIDTH'(abs_u(ABS_MAX_W'(dividend)));
            d_q         <= WIDTH'(abs_u(ABS_MAX_W'(divisor)));
            p_q         <= '0;
            cntr        <= '0;
            div_by_zero <= zero_div;
            if (zero_div) begin
              quotient  <= '1;
              remainder <= dividend;
            end
          end
        end
        ITER: begin
          p_q  <= p_step;
          a_q  <= a_step;
          cntr <= (cntr == LAST) ? cntr : cntr + 1'b1;
        end
        FIX: begin
          quotient  <= quot_nxt;
          remainder <= rem_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule
